// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request at a time,
// prioritised redirects (trap > ex branch > id jump) and a one-entry buffer to decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_stall,
    input  logic        trap_valid,
    input  logic [31:0] trap_addr,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_br_addr,
    input  logic        id_jmp_valid,
    input  logic [31:0] id_jmp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        load;

    // Redirect targets are word aligned by clearing the low two bits.
    always_comb begin
        redirect = trap_valid | ex_br_valid | id_jmp_valid;
        if (trap_valid) begin
            redirect_addr = trap_addr & ~32'h3;
        end else if (ex_br_valid) begin
            redirect_addr = ex_br_addr & ~32'h3;
        end else begin
            redirect_addr = id_jmp_addr & ~32'h3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    // A response is only kept when it completes in WAIT with no redirect.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redirect && (!if_valid_q || !hz_stall)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    state_d = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                    load    = !redirect;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if (redirect) begin
            pc_d       = redirect_addr;
            if_valid_d = 1'b0;
        end else if (load) begin
            pc_d       = pc_q + 32'd4;
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
        end else if (if_valid_q && !hz_stall) begin
            if_valid_d = 1'b0;
        end
    end

    always_comb begin
        imem_req  = (state_q == REQ);
        imem_addr = pc_q;
        flush_o   = redirect & ~rst;
        if_valid  = if_valid_q;
        if_pc     = if_pc_q;
        if_instr  = if_valid_q ? if_instr_q : NOP_INSTR;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a scoreboard checks granted addresses and
// delivered instructions, while timed checks cover reset, stalls and redirects.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        hz_stall;
    logic        trap_valid;
    logic [31:0] trap_addr;
    logic        ex_br_valid;
    logic [31:0] ex_br_addr;
    logic        id_jmp_valid;
    logic [31:0] id_jmp_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          rsp_lat  = 1;
    logic [31:0] addr_q[$];
    logic [63:0] fetch_q[$];

    fetch_ctrl #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hz_stall     (hz_stall),
        .trap_valid   (trap_valid),
        .trap_addr    (trap_addr),
        .ex_br_valid  (ex_br_valid),
        .ex_br_addr   (ex_br_addr),
        .id_jmp_valid (id_jmp_valid),
        .id_jmp_addr  (id_jmp_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .flush_o      (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            n_pass++;
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic trap, input logic br,
                                 input logic jmp, input logic gnt, input logic reset);
        @(posedge clk);
        #1;
        hz_stall     = stall;
        trap_valid   = trap;
        ex_br_valid  = br;
        id_jmp_valid = jmp;
        imem_gnt     = gnt;
        rst          = reset;
    endtask

    // Memory model: answers a granted request rsp_lat cycles later with ~address.
    initial begin
        logic        rsp_pend;
        int          rsp_cnt;
        logic [31:0] rsp_addr;
        rsp_pend    = 1'b0;
        rsp_cnt     = 0;
        rsp_addr    = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
                rsp_pend = 1'b1;
                rsp_cnt  = rsp_lat;
                rsp_addr = imem_addr;
            end
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = ~rsp_addr;
                    rsp_pend    = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: granted requests and each newly buffered instruction.
    initial begin
        logic        valid_prev;
        logic [63:0] exp_fetch;
        valid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_req: got addr %h, expected no request", imem_addr);
                end else begin
                    checkOutput("sb_imem_addr", imem_addr, addr_q.pop_front());
                end
            end
            if (if_valid === 1'b1 && !valid_prev) begin
                if (fetch_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_fetch: got pc %h instr %h, expected none", if_pc, if_instr);
                end else begin
                    exp_fetch = fetch_q.pop_front();
                    checkOutput("sb_if_pc", if_pc, exp_fetch[63:32]);
                    checkOutput("sb_if_instr", if_instr, exp_fetch[31:0]);
                end
            end
            valid_prev = (if_valid === 1'b1);
        end
    end

    initial begin
        rst          = 1'b1;
        hz_stall     = 1'b0;
        trap_valid   = 1'b0;
        ex_br_valid  = 1'b0;
        id_jmp_valid = 1'b0;
        trap_addr    = 32'h0000_0100;
        ex_br_addr   = 32'h0000_0200;
        id_jmp_addr  = 32'h0000_0300;
        imem_gnt     = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_instr", if_instr, NOP_INSTR);
        checkOutput("rst_flush", {31'b0, flush_o}, 32'd0);

        // Back-to-back fetches from the reset PC
        addr_q.push_back(32'h0000_0000);
        fetch_q.push_back({32'h0000_0000, 32'hFFFF_FFFF});
        addr_q.push_back(32'h0000_0004);
        fetch_q.push_back({32'h0000_0004, 32'hFFFF_FFFB});
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("release_req_low", {31'b0, imem_req}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("first_req", {31'b0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, RESET_PC);
        repeat (4) applyStimulus(0, 0, 0, 0, 1, 0);

        // Decode stall holds the buffer and blocks new requests
        applyStimulus(1, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("stall_req_0", {31'b0, imem_req}, 32'd0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("stall_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("stall_pc", if_pc, 32'h0000_0004);
        checkOutput("stall_instr", if_instr, 32'hFFFF_FFFB);
        checkOutput("stall_req_1", {31'b0, imem_req}, 32'd0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("stall_req_2", {31'b0, imem_req}, 32'd0);
        checkOutput("stall_pc_2", if_pc, 32'h0000_0004);
        addr_q.push_back(32'h0000_0008);
        fetch_q.push_back({32'h0000_0008, 32'hFFFF_FFF7});
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("unstall_req_low", {31'b0, imem_req}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("unstall_req", {31'b0, imem_req}, 32'd1);
        checkOutput("unstall_addr", imem_addr, 32'h0000_0008);
        repeat (2) applyStimulus(0, 0, 0, 0, 1, 0);

        // All three redirects at once while ungranted: the trap wins
        addr_q.push_back(32'h0000_0100);
        fetch_q.push_back({32'h0000_0100, 32'hFFFF_FEFF});
        applyStimulus(0, 1, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("prio_flush", {31'b0, flush_o}, 32'd1);
        checkOutput("prio_req_held", {31'b0, imem_req}, 32'd1);
        checkOutput("prio_old_addr", imem_addr, 32'h0000_000C);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("prio_new_addr", imem_addr, 32'h0000_0100);
        repeat (2) applyStimulus(0, 0, 0, 0, 1, 0);

        // Branch during WAIT: the late response must be dropped
        addr_q.push_back(32'h0000_0104);
        addr_q.push_back(32'h0000_0080);
        fetch_q.push_back({32'h0000_0080, 32'hFFFF_FF7F});
        applyStimulus(0, 0, 0, 0, 1, 0);
        rsp_lat = 3;
        ex_br_addr = 32'h0000_0083;
        applyStimulus(0, 0, 1, 0, 1, 0);
        @(negedge clk);
        checkOutput("br_flush", {31'b0, flush_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("drop_req", {31'b0, imem_req}, 32'd0);
        checkOutput("drop_valid", {31'b0, if_valid}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        rsp_lat = 1;
        @(negedge clk);
        checkOutput("drop_rvalid_valid", {31'b0, if_valid}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("dropped_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("dropped_req", {31'b0, imem_req}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("br_req", {31'b0, imem_req}, 32'd1);
        checkOutput("br_addr", imem_addr, 32'h0000_0080);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Jump to the top word, then the PC wraps to zero
        id_jmp_addr = 32'hFFFF_FFFC;
        addr_q.push_back(32'hFFFF_FFFC);
        fetch_q.push_back({32'hFFFF_FFFC, 32'h0000_0003});
        addr_q.push_back(32'h0000_0000);
        fetch_q.push_back({32'h0000_0000, 32'hFFFF_FFFF});
        applyStimulus(0, 0, 0, 1, 1, 0);
        @(negedge clk);
        checkOutput("jmp_flush", {31'b0, flush_o}, 32'd1);
        checkOutput("jmp_valid_before", {31'b0, if_valid}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("jmp_valid_cleared", {31'b0, if_valid}, 32'd0);
        checkOutput("jmp_idle_req", {31'b0, imem_req}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
        repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
        repeat (2) applyStimulus(0, 0, 0, 0, 1, 0);

        // Reset while waiting; the response that follows must be ignored
        rsp_lat = 2;
        addr_q.push_back(32'h0000_0004);
        addr_q.push_back(RESET_PC);
        fetch_q.push_back({RESET_PC, 32'hFFFF_FFFF});
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("pre_rst_addr", imem_addr, 32'h0000_0004);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        rsp_lat = 1;
        @(negedge clk);
        checkOutput("post_rst_valid", {31'b0, if_valid}, 32'd0);
        checkOutput("post_rst_instr", if_instr, NOP_INSTR);
        checkOutput("post_rst_req_low", {31'b0, imem_req}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("post_rst_req", {31'b0, imem_req}, 32'd1);
        checkOutput("post_rst_addr", imem_addr, RESET_PC);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        checkOutput("addr_q_drained", addr_q.size(), 32'd0);
        checkOutput("fetch_q_drained", fetch_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
